// File: rtl/wb_commit_if.sv
// W-stage bundle: MEM/WB pipeline register fields in, GPR write port,
// HI/LO bypass and debug trace out.
interface wb_commit_if;
  logic        validW;
  logic        stallW;
  logic [31:0] aluoutW;
  logic [31:0] readdataW;
  logic [4:0]  writeregW;
  logic [31:0] hi_oW;
  logic [31:0] lo_oW;
  logic [31:0] srcaW;
  logic [1:0]  memtoregW;
  logic        regwriteW;
  logic [7:0]  alucontrolW;
  logic        gprtohiW;
  logic        gprtoloW;

  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] hi_rd;
  logic [31:0] lo_rd;
  logic [31:0] instret;
  logic [4:0]  trace_pc_wreg;
  logic [31:0] trace_wdata;
  logic        trace_valid;

  modport master (
    output validW, stallW, aluoutW, readdataW, writeregW, hi_oW, lo_oW,
           srcaW, memtoregW, regwriteW, alucontrolW, gprtohiW, gprtoloW,
    input  rf_we, rf_waddr, rf_wdata, hi_rd, lo_rd, instret,
           trace_pc_wreg, trace_wdata, trace_valid
  );

  modport slave (
    input  validW, stallW, aluoutW, readdataW, writeregW, hi_oW, lo_oW,
           srcaW, memtoregW, regwriteW, alucontrolW, gprtohiW, gprtoloW,
    output rf_we, rf_waddr, rf_wdata, hi_rd, lo_rd, instret,
           trace_pc_wreg, trace_wdata, trace_valid
  );
endinterface

// File: rtl/wb_commit.sv
// W-stage commit: result select, GPR write port, architectural HI/LO with
// same-cycle bypass to E, retired-instruction counter and last-commit trace.
module wb_commit #(
  parameter logic [7:0] ALU_MULT  = 8'h18,
  parameter logic [7:0] ALU_MULTU = 8'h19,
  parameter logic [7:0] ALU_DIV   = 8'h1A,
  parameter logic [7:0] ALU_DIVU  = 8'h1B
) (
  input  logic        clk,
  input  logic        rst,
  wb_commit_if.slave  w
);

  logic        commit;
  logic        is_md;
  logic        hi_we, lo_we;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] instret_q, instret_d;
  logic [4:0]  trace_wreg_q, trace_wreg_d;
  logic [31:0] trace_wdata_q, trace_wdata_d;
  logic        trace_valid_q;
  logic [31:0] result;
  logic        rf_we;

  // rst in the term keeps the write port quiet while reset is asserted
  assign commit = w.validW & ~w.stallW & rst;

  assign is_md = (w.alucontrolW == ALU_MULT) || (w.alucontrolW == ALU_MULTU) ||
                 (w.alucontrolW == ALU_DIV)  || (w.alucontrolW == ALU_DIVU);

  assign hi_we = commit & (w.gprtohiW | is_md);
  assign lo_we = commit & (w.gprtoloW | is_md);

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (hi_we) hi_d = w.gprtohiW ? w.srcaW : w.hi_oW;
    if (lo_we) lo_d = w.gprtoloW ? w.srcaW : w.lo_oW;
  end

  // MFHI/MFLO read the pre-update register, not the bypassed value
  always_comb begin
    result = w.aluoutW;
    unique case (w.memtoregW)
      2'b00: result = w.aluoutW;
      2'b01: result = w.readdataW;
      2'b10: result = hi_q;
      2'b11: result = lo_q;
      default: result = w.aluoutW;
    endcase
  end

  assign rf_we = commit & w.regwriteW & (w.writeregW != 5'd0);

  always_comb begin
    instret_d     = commit ? instret_q + 32'd1 : instret_q;
    trace_wreg_d  = rf_we ? w.writeregW : trace_wreg_q;
    trace_wdata_d = rf_we ? result      : trace_wdata_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_q          <= '0;
      lo_q          <= '0;
      instret_q     <= '0;
      trace_wreg_q  <= '0;
      trace_wdata_q <= '0;
      trace_valid_q <= 1'b0;
    end else begin
      hi_q          <= hi_d;
      lo_q          <= lo_d;
      instret_q     <= instret_d;
      trace_wreg_q  <= trace_wreg_d;
      trace_wdata_q <= trace_wdata_d;
      trace_valid_q <= rf_we;
    end
  end

  assign w.rf_we         = rf_we;
  assign w.rf_waddr      = w.writeregW;
  assign w.rf_wdata      = result;
  assign w.hi_rd         = hi_d;
  assign w.lo_rd         = lo_d;
  assign w.instret       = instret_q;
  assign w.trace_pc_wreg = trace_wreg_q;
  assign w.trace_wdata   = trace_wdata_q;
  assign w.trace_valid   = trace_valid_q;

endmodule

// File: tb/tb_wb_commit.sv
// Randomized bench for wb_commit against an architectural-level model of
// HI/LO, the retire count and the last GPR commit.
module tb_wb_commit;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  wb_commit_if wif ();
  wb_commit dut (.clk(clk), .rst(rst), .w(wif));

  int n_chk = 0;
  int n_pass = 0;

  // architectural state of the model
  logic [31:0] m_hi, m_lo, m_instret, m_twdata;
  logic [4:0]  m_twreg;
  logic        m_tvalid;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic model_reset();
    m_hi = 0; m_lo = 0; m_instret = 0; m_twdata = 0; m_twreg = 0; m_tvalid = 0;
  endtask

  task automatic idle();
    wif.validW = 0; wif.stallW = 0; wif.aluoutW = 0; wif.readdataW = 0;
    wif.writeregW = 0; wif.hi_oW = 0; wif.lo_oW = 0; wif.srcaW = 0;
    wif.memtoregW = 0; wif.regwriteW = 0; wif.alucontrolW = 0;
    wif.gprtohiW = 0; wif.gprtoloW = 0;
  endtask

  // Inputs are already applied (after a negedge). Check, then advance one edge.
  task automatic cyc();
    logic        c, md, we;
    logic [31:0] res, nhi, nlo;
    #1;
    c  = wif.validW && !wif.stallW && rst;
    md = wif.alucontrolW inside {8'h18, 8'h19, 8'h1A, 8'h1B};
    case (wif.memtoregW)
      2'd0: res = wif.aluoutW;
      2'd1: res = wif.readdataW;
      2'd2: res = m_hi;
      default: res = m_lo;
    endcase
    we  = c && wif.regwriteW && wif.writeregW != 0;
    nhi = !c ? m_hi : wif.gprtohiW ? wif.srcaW : md ? wif.hi_oW : m_hi;
    nlo = !c ? m_lo : wif.gprtoloW ? wif.srcaW : md ? wif.lo_oW : m_lo;
    chk("rf_we", {31'd0, wif.rf_we}, {31'd0, we});
    chk("rf_waddr", {27'd0, wif.rf_waddr}, {27'd0, wif.writeregW});
    chk("rf_wdata", wif.rf_wdata, res);
    chk("hi_rd", wif.hi_rd, nhi);
    chk("lo_rd", wif.lo_rd, nlo);
    chk("instret", wif.instret, m_instret);
    chk("trace_valid", {31'd0, wif.trace_valid}, {31'd0, m_tvalid});
    chk("trace_wreg", {27'd0, wif.trace_pc_wreg}, {27'd0, m_twreg});
    chk("trace_wdata", wif.trace_wdata, m_twdata);
    @(posedge clk);
    if (rst) begin
      m_hi = nhi; m_lo = nlo;
      if (c) m_instret = m_instret + 1;
      m_tvalid = we;
      if (we) begin m_twreg = wif.writeregW; m_twdata = res; end
    end
    @(negedge clk);
  endtask

  initial begin
    idle();
    model_reset();
    @(negedge clk);
    wif.validW = 1; wif.regwriteW = 1; wif.writeregW = 5'd3;
    #1;
    chk("reset_rf_we", {31'd0, wif.rf_we}, 32'd0);
    chk("reset_instret", wif.instret, 32'd0);
    chk("reset_hi_rd", wif.hi_rd, 32'd0);
    idle();
    @(negedge clk);
    rst = 1;

    // plain ALU writeback
    wif.validW = 1; wif.regwriteW = 1; wif.writeregW = 5; wif.aluoutW = 32'h1234;
    #1;
    chk("t1_rf_we", {31'd0, wif.rf_we}, 32'd1);
    chk("t1_rf_wdata", wif.rf_wdata, 32'h1234);
    #1; cyc();
    chk("t1_trace_wdata", wif.trace_wdata, 32'h1234);
    chk("t1_instret", wif.instret, 32'd1);

    // $0 write suppressed, still retires
    wif.writeregW = 0; cyc();
    chk("t2_trace_valid", {31'd0, wif.trace_valid}, 32'd0);
    chk("t2_instret", wif.instret, 32'd2);

    // MULT bypass then MFHI
    wif.alucontrolW = 8'h18; wif.hi_oW = 32'hA; wif.lo_oW = 32'hB; wif.regwriteW = 0;
    #1;
    chk("t3_hi_bypass", wif.hi_rd, 32'hA);
    chk("t3_lo_bypass", wif.lo_rd, 32'hB);
    cyc();
    idle(); wif.validW = 1; wif.regwriteW = 1; wif.writeregW = 7; wif.memtoregW = 2'b10;
    #1;
    chk("t3_mfhi", wif.rf_wdata, 32'hA);
    cyc();

    // MTHI beats DIV on HI only
    idle(); wif.validW = 1; wif.gprtohiW = 1; wif.srcaW = 32'h55;
    wif.alucontrolW = 8'h1A; wif.hi_oW = 32'h77; wif.lo_oW = 32'h88;
    cyc();
    idle();
    #1;
    chk("t4_hi", wif.hi_rd, 32'h55);
    chk("t4_lo", wif.lo_rd, 32'h88);

    // stalled MTLO for 3 cycles, then released
    wif.validW = 1; wif.stallW = 1; wif.gprtoloW = 1; wif.srcaW = 32'h9;
    repeat (3) cyc();
    chk("t5_lo_held", wif.lo_rd, 32'h88);
    chk("t5_instret_held", wif.instret, m_instret);
    wif.stallW = 0; cyc();
    idle();
    #1;
    chk("t5_lo", wif.lo_rd, 32'h9);

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      wif.validW      = ($urandom_range(0, 9) < 8);
      wif.stallW      = ($urandom_range(0, 9) < 2);
      wif.aluoutW     = $urandom;
      wif.readdataW   = $urandom;
      wif.writeregW   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      wif.hi_oW       = $urandom;
      wif.lo_oW       = $urandom;
      wif.srcaW       = $urandom;
      wif.memtoregW   = 2'($urandom);
      wif.regwriteW   = ($urandom_range(0, 3) != 0);
      wif.alucontrolW = ($urandom_range(0, 2) == 0) ? 8'(8'h18 + $urandom_range(0, 3))
                                                    : 8'($urandom);
      wif.gprtohiW    = ($urandom_range(0, 6) == 0);
      wif.gprtoloW    = ($urandom_range(0, 6) == 0);
      cyc();
    end

    // counter wrap
    idle();
    force dut.instret_q = 32'hFFFF_FFFF;
    #1;
    release dut.instret_q;
    m_instret = 32'hFFFF_FFFF;
    wif.validW = 1; wif.regwriteW = 1; wif.writeregW = 9; wif.aluoutW = 32'hBEEF;
    cyc();
    chk("wrap_instret", wif.instret, 32'd0);

    // async reset mid-cycle, commit still requested
    wif.gprtohiW = 1; wif.srcaW = 32'h123;
    @(posedge clk); #2;
    rst = 0;
    #1;
    chk("arst_instret", wif.instret, 32'd0);
    chk("arst_trace_valid", {31'd0, wif.trace_valid}, 32'd0);
    chk("arst_trace_wdata", wif.trace_wdata, 32'd0);
    chk("arst_trace_wreg", {27'd0, wif.trace_pc_wreg}, 32'd0);
    chk("arst_rf_we", {31'd0, wif.rf_we}, 32'd0);
    chk("arst_hi_rd", wif.hi_rd, 32'd0);
    chk("arst_lo_rd", wif.lo_rd, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/wb_commit.md
Name: wb_commit

Overview:
- Consumer end of the MEM/WB pipeline register; sits in the W stage, the final stage of the 5-stage MIPS pipeline.
- Selects the writeback result and drives the GPR write port.
- Owns the architectural HI/LO registers and commits MTHI/MTLO/MULT/DIV results to them.
- Provides bypassed HI/LO to the E stage and keeps a retired-instruction counter plus a last-commit trace for debug.

Parameters:
- ALU_MULT, 8'h18, alucontrol code for MULT
- ALU_MULTU, 8'h19, alucontrol code for MULTU
- ALU_DIV, 8'h1A, alucontrol code for DIV
- ALU_DIVU, 8'h1B, alucontrol code for DIVU

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset (rst=0 resets)
- validW  in  1  W-stage slot holds a real instruction (0 = bubble)
- stallW  in  1  freeze W stage; no commits this cycle
- aluoutW  in  32  ALU result
- readdataW  in  32  load data, already extended
- writeregW  in  5  destination GPR
- hi_oW  in  32  HI half of mult/div result
- lo_oW  in  32  LO half of mult/div result
- srcaW  in  32  rs value for MTHI/MTLO
- memtoregW  in  2  result select
- regwriteW  in  1  GPR write request
- alucontrolW  in  8  operation code
- gprtohiW  in  1  MTHI
- gprtoloW  in  1  MTLO
- rf_we  out  1  GPR write enable (combinational)
- rf_waddr  out  5  GPR write address (combinational)
- rf_wdata  out  32  GPR write data (combinational)
- hi_rd  out  32  bypassed HI for E stage (combinational)
- lo_rd  out  32  bypassed LO for E stage (combinational)
- instret  out  32  retired-instruction counter (registered)
- trace_pc_wreg  out  5  last committed destination register (registered)
- trace_wdata  out  32  last committed write data (registered)
- trace_valid  out  1  one-cycle pulse per GPR commit (registered)

Behaviour:
- commit = validW & ~stallW & rst. Every write below is gated by commit.
- Result mux on memtoregW:
  - 00: aluoutW
  - 01: readdataW
  - 10: HI register, pre-update value
  - 11: LO register, pre-update value
- rf_we = commit & regwriteW & (writeregW != 0). Writes to $0 are suppressed.
- rf_waddr = writeregW; rf_wdata = mux result.
- HI update at posedge when commit:
  - gprtohiW: HI <= srcaW.
  - else alucontrolW in {MULT, MULTU, DIV, DIVU}: HI <= hi_oW.
  - else hold.
- LO update: same as HI, using gprtoloW and lo_oW.
- If gprtohiW and a mult/div code are both set, MTHI wins for HI only; LO still takes lo_oW unless gprtoloW is set.
- hi_rd / lo_rd bypass: when commit and a HI (or LO) write is pending this cycle, drive the value being written; otherwise drive the register. Zero added latency, so E stage sees W-stage writes in the same cycle.
- instret: increments by 1 on each commit, bubbles and stalls excluded. Wraps 32'hFFFFFFFF -> 0.
- Trace registers:
  - trace_valid <= rf_we each cycle.
  - When rf_we: trace_pc_wreg <= writeregW, trace_wdata <= rf_wdata.
  - Otherwise trace_pc_wreg and trace_wdata hold.
- Reset (rst=0, asynchronous, any time including mid-stall):
  - HI, LO, instret, trace_pc_wreg, trace_wdata, trace_valid clear to 0 immediately.
  - Combinational outputs follow: rf_we=0, hi_rd=lo_rd=0.
- Release of rst is synchronous-safe. The first commit possible is the first rising edge with rst=1.
- stallW=1 holds every register, including HI/LO/instret, for any number of cycles. Inputs presented during a stall are ignored.

Test Plan:
- Reset, then validW=1, regwriteW=1, writeregW=5, memtoregW=00, aluoutW=32'h1234 -> rf_we=1, rf_waddr=5, rf_wdata=32'h1234; next cycle trace_valid=1, trace_wdata=32'h1234, instret=1.
- writeregW=0 with regwriteW=1, validW=1 -> rf_we=0, trace_valid=0 next cycle, instret still increments.
- alucontrolW=ALU_MULT, hi_oW=32'hA, lo_oW=32'hB -> hi_rd=A and lo_rd=B in the same cycle. Next cycle, an MFHI (memtoregW=10) gives rf_wdata=32'hA.
- gprtohiW=1, srcaW=32'h55, alucontrolW=ALU_DIV, hi_oW=32'h77, lo_oW=32'h88 -> HI=32'h55, LO=32'h88.
- stallW=1 for 3 cycles with MTLO srcaW=32'h9 -> LO unchanged, instret unchanged, rf_we=0. After stall drops: LO=32'h9, instret+1.
- Preload instret via 2^32-1 commits (force in sim), commit once -> instret=0. Then assert rst=0 mid-cycle -> all registered outputs 0 before the next edge.
